// File: rtl/serial_io_chain.sv
// serial_io_chain: one engine that, in a single frame, shifts a word into a
// daisy-chained 595-style output register and reads a 165-style input chain.
// Frame: IDLE -> LOAD (input parallel load) -> SHIFT (FRAME bits) -> LATCH
// (output commit) -> DONE (publish captured word) -> IDLE or LOAD.
// Optional feature macro: SERIAL_IO_CHANGE_EN adds the per-bit change mask
// o_InChanged; without it o_InChanged is tied to zero.
module serial_io_chain #(
    parameter int OUT_WIDTH  = 16,
    parameter int IN_WIDTH   = 16,
    parameter int CLK_DIV    = 2,
    parameter int CONTINUOUS = 0
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET,
    input  logic                 i_Start,
    input  logic [OUT_WIDTH-1:0] i_OutData,
    output logic                 o_Busy,
    output logic                 o_SCLK,
    output logic                 o_SerOut,
    output logic                 o_OutLatch,
    input  logic                 i_SerIn,
    output logic                 o_InLatch,
    output logic [IN_WIDTH-1:0]  o_InData,
    output logic                 o_Valid,
    output logic [IN_WIDTH-1:0]  o_InChanged
);

    // Longer of the two chains sets the number of shift clocks per frame.
    localparam int FRAME = (OUT_WIDTH > IN_WIDTH) ? OUT_WIDTH : IN_WIDTH;
    // Every timed phase (LOAD, one bit of SHIFT, LATCH) lasts 2*CLK_DIV cycles.
    localparam int PHASE = 2 * CLK_DIV;
    localparam int CNT_W = (PHASE > 1) ? $clog2(PHASE) : 1;
    localparam int BIT_W = $clog2(FRAME + 1);

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE - 1);
    localparam logic [CNT_W-1:0] SCLK_HIGH  = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] SAMPLE_AT  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME - 1);
    localparam logic [BIT_W-1:0] IN_BITS    = BIT_W'(IN_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    phase_reg, phase_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [FRAME-1:0]    out_shift_reg, out_shift_next;
    logic [IN_WIDTH-1:0] in_shift_reg, in_shift_next;
    logic [IN_WIDTH-1:0] in_data_reg;

    logic busy_reg, busy_next;
    logic sclk_reg, sclk_next;
    logic ser_out_reg, ser_out_next;
    logic out_latch_reg, out_latch_next;
    logic in_latch_reg, in_latch_next;
    logic valid_reg, valid_next;
    logic load_word;
    logic phase_last;

    assign phase_last = (phase_reg == PHASE_LAST);

    // Next-state, counters, shift/capture registers and next output values.
    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        bit_next       = bit_reg;
        out_shift_next = out_shift_reg;
        in_shift_next  = in_shift_reg;
        load_word      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                phase_next = '0;
                bit_next   = '0;
                if ((CONTINUOUS != 0) || i_Start) begin
                    state_next = ST_LOAD;
                    load_word  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (phase_last) begin
                    phase_next = '0;
                    bit_next   = '0;
                    state_next = ST_SHIFT;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            ST_SHIFT: begin
                // SCLK rises on the edge leaving phase CLK_DIV-1: sample here,
                // while the input chain still presents the current bit.
                if ((phase_reg == SAMPLE_AT) && (bit_reg < IN_BITS)) begin
                    in_shift_next = (in_shift_reg << 1) | IN_WIDTH'(i_SerIn);
                end
                if (phase_last) begin
                    phase_next     = '0;
                    out_shift_next = out_shift_reg << 1;
                    if (bit_reg == BIT_LAST) begin
                        state_next = ST_LATCH;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            ST_LATCH: begin
                if (phase_last) begin
                    phase_next = '0;
                    state_next = ST_DONE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            ST_DONE: begin
                phase_next = '0;
                bit_next   = '0;
                if (CONTINUOUS != 0) begin
                    state_next = ST_LOAD;
                    load_word  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
                bit_next   = '0;
            end
        endcase

        // Zero-extension puts the pad bits on top, so they are sent first.
        if (load_word) begin
            out_shift_next = FRAME'(i_OutData);
        end

        // Outputs are derived from the next state and registered, so they
        // line up with the state they describe and cannot glitch.
        busy_next      = (state_next != ST_IDLE);
        sclk_next      = (state_next == ST_SHIFT) && (phase_next >= SCLK_HIGH);
        ser_out_next   = (state_next == ST_SHIFT) ? out_shift_next[FRAME-1] : 1'b0;
        in_latch_next  = (state_next == ST_LOAD);
        out_latch_next = (state_next == ST_LATCH);
        valid_next     = (state_next == ST_DONE);
    end

    // State, counters, data path and registered outputs.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            bit_reg       <= '0;
            out_shift_reg <= '0;
            in_shift_reg  <= '0;
            in_data_reg   <= '0;
            busy_reg      <= 1'b0;
            sclk_reg      <= 1'b0;
            ser_out_reg   <= 1'b0;
            out_latch_reg <= 1'b0;
            in_latch_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            bit_reg       <= bit_next;
            out_shift_reg <= out_shift_next;
            in_shift_reg  <= in_shift_next;
            busy_reg      <= busy_next;
            sclk_reg      <= sclk_next;
            ser_out_reg   <= ser_out_next;
            out_latch_reg <= out_latch_next;
            in_latch_reg  <= in_latch_next;
            valid_reg     <= valid_next;
            if (valid_next) begin
                in_data_reg <= in_shift_reg;
            end
        end
    end

`ifdef SERIAL_IO_CHANGE_EN
    logic [IN_WIDTH-1:0] changed_reg;

    // Change mask against the previously published word, updated with o_Valid.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            changed_reg <= '0;
        end else if (valid_next) begin
            changed_reg <= in_shift_reg ^ in_data_reg;
        end
    end

    assign o_InChanged = changed_reg;
`else
    assign o_InChanged = '0;
`endif

    assign o_Busy     = busy_reg;
    assign o_SCLK     = sclk_reg;
    assign o_SerOut   = ser_out_reg;
    assign o_OutLatch = out_latch_reg;
    assign o_InLatch  = in_latch_reg;
    assign o_InData   = in_data_reg;
    assign o_Valid    = valid_reg;

endmodule

// File: tb/tb_serial_io_chain.sv
// Bench for serial_io_chain: three instances (default, 8-out/24-in, continuous),
// each with a 595-style output chain model and a 165-style input chain model.
module tb_serial_io_chain;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int overlap_errs = 0;

    // ---------------- instance a: defaults ----------------
    logic        start_a = 1'b0;
    logic [15:0] out_data_a = '0;
    logic        busy_a, sclk_a, ser_out_a, out_latch_a, ser_in_a, in_latch_a, valid_a;
    logic [15:0] in_data_a, changed_a;
    logic [15:0] in_word_a = '0, chain_in_a = '0, chain_out_a = '0, latched_a = '0;
    int          sclk_rises_a = 0, latch_pulses_a = 0, latch_cycles_a = 0;

    serial_io_chain u_dut_a (
        .i_CLK(clk), .i_RESET(rst), .i_Start(start_a), .i_OutData(out_data_a),
        .o_Busy(busy_a), .o_SCLK(sclk_a), .o_SerOut(ser_out_a), .o_OutLatch(out_latch_a),
        .i_SerIn(ser_in_a), .o_InLatch(in_latch_a), .o_InData(in_data_a),
        .o_Valid(valid_a), .o_InChanged(changed_a)
    );

    // ---------------- instance b: 8 out, 24 in ----------------
    logic        start_b = 1'b0;
    logic [7:0]  out_data_b = '0;
    logic        busy_b, sclk_b, ser_out_b, out_latch_b, ser_in_b, in_latch_b, valid_b;
    logic [23:0] in_data_b, changed_b;
    logic [23:0] in_word_b = '0, chain_in_b = '0, chain_out_b = '0, latched_b = '0;
    int          sclk_rises_b = 0;

    serial_io_chain #(.OUT_WIDTH(8), .IN_WIDTH(24)) u_dut_b (
        .i_CLK(clk), .i_RESET(rst), .i_Start(start_b), .i_OutData(out_data_b),
        .o_Busy(busy_b), .o_SCLK(sclk_b), .o_SerOut(ser_out_b), .o_OutLatch(out_latch_b),
        .i_SerIn(ser_in_b), .o_InLatch(in_latch_b), .o_InData(in_data_b),
        .o_Valid(valid_b), .o_InChanged(changed_b)
    );

    // ---------------- instance c: continuous ----------------
    logic        start_c = 1'b0;
    logic [15:0] out_data_c = 16'h0F0F;
    logic        busy_c, sclk_c, ser_out_c, out_latch_c, ser_in_c, in_latch_c, valid_c;
    logic [15:0] in_data_c, changed_c;
    logic [15:0] in_word_c = 16'hBEEF, chain_in_c = '0, chain_out_c = '0, latched_c = '0;

    serial_io_chain #(.CONTINUOUS(1)) u_dut_c (
        .i_CLK(clk), .i_RESET(rst), .i_Start(start_c), .i_OutData(out_data_c),
        .o_Busy(busy_c), .o_SCLK(sclk_c), .o_SerOut(ser_out_c), .o_OutLatch(out_latch_c),
        .i_SerIn(ser_in_c), .o_InLatch(in_latch_c), .o_InData(in_data_c),
        .o_Valid(valid_c), .o_InChanged(changed_c)
    );

    // ---------------- chain models ----------------
    assign ser_in_a = chain_in_a[15];
    assign ser_in_b = chain_in_b[23];
    assign ser_in_c = chain_in_c[15];

    always @(posedge sclk_a or posedge in_latch_a)
        if (in_latch_a) chain_in_a <= in_word_a; else chain_in_a <= chain_in_a << 1;
    always @(posedge sclk_b or posedge in_latch_b)
        if (in_latch_b) chain_in_b <= in_word_b; else chain_in_b <= chain_in_b << 1;
    always @(posedge sclk_c or posedge in_latch_c)
        if (in_latch_c) chain_in_c <= in_word_c; else chain_in_c <= chain_in_c << 1;

    always @(posedge sclk_a) begin
        chain_out_a <= {chain_out_a[14:0], ser_out_a};
        sclk_rises_a++;
    end
    always @(posedge sclk_b) begin
        chain_out_b <= {chain_out_b[22:0], ser_out_b};
        sclk_rises_b++;
    end
    always @(posedge sclk_c) chain_out_c <= {chain_out_c[14:0], ser_out_c};

    always @(posedge out_latch_a) begin
        latched_a <= chain_out_a;
        latch_pulses_a++;
    end
    always @(posedge out_latch_b) latched_b <= chain_out_b;
    always @(posedge out_latch_c) latched_c <= chain_out_c;

    // Strobe exclusivity monitor and latch-width counter.
    always @(negedge clk) begin
        if (out_latch_a) latch_cycles_a++;
        if ((in_latch_a && out_latch_a) || (sclk_a && (in_latch_a || out_latch_a))) overlap_errs++;
        if ((in_latch_b && out_latch_b) || (sclk_b && (in_latch_b || out_latch_b))) overlap_errs++;
        if ((in_latch_c && out_latch_c) || (sclk_c && (in_latch_c || out_latch_c))) overlap_errs++;
    end

    // i_Start on the continuous instance toggles randomly and must not matter.
    always @(negedge clk) start_c = 1'($urandom_range(0, 1));

    // ---------------- helpers ----------------
    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_valid(input int which);
        case (which)
            0:       return valid_a;
            1:       return valid_b;
            default: return valid_c;
        endcase
    endfunction

    // Counts negedges (current one = 1) until o_Valid is seen, bounded.
    task automatic wait_valid(input int which, input int budget, output int cycles);
        cycles = 1;
        while (!cur_valid(which) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_frame_a(input string name, input logic [15:0] out_w,
                               input logic [15:0] in_w, input logic [15:0] exp_chg);
        int cyc;
        out_data_a     = out_w;
        in_word_a      = in_w;
        sclk_rises_a   = 0;
        latch_pulses_a = 0;
        latch_cycles_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        check_value({name, "_busy_start"}, busy_a, 1'b1);
        check_value({name, "_inlatch_start"}, in_latch_a, 1'b1);
        wait_valid(0, 200, cyc);
        check_value({name, "_valid_cycle"}, cyc, 73);
        check_value({name, "_in_data"}, in_data_a, in_w);
        check_value({name, "_changed"}, changed_a, exp_chg);
        check_value({name, "_latched_out"}, latched_a, out_w);
        check_value({name, "_sclk_rises"}, sclk_rises_a, 16);
        check_value({name, "_outlatch_cycles"}, latch_cycles_a, 4);
        check_value({name, "_outlatch_pulses"}, latch_pulses_a, 1);
        @(negedge clk);
        check_value({name, "_busy_after"}, busy_a, 1'b0);
        check_value({name, "_valid_pulse"}, valid_a, 1'b0);
        $display("frame %s: out=%h in=%h cycles=%0d changed=%h", name, out_w, in_data_a, cyc, changed_a);
    endtask

    logic [15:0] exp_chg;

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int busy_cnt;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_outputs_a", {busy_a, sclk_a, ser_out_a, out_latch_a, in_latch_a, valid_a}, 6'b0);
        check_value("rst_in_data_a", in_data_a, 16'h0);
        check_value("rst_busy_c", busy_c, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: A5C3 out, 1234 in
`ifdef SERIAL_IO_CHANGE_EN
        exp_chg = 16'h1234;
`else
        exp_chg = 16'h0000;
`endif
        run_frame_a("t1", 16'hA5C3, 16'h1234, exp_chg);

        // Start pulse during SHIFT and mid-frame data change are ignored
        out_data_a = 16'h3C5A;
        in_word_a  = 16'h5678;
        latch_pulses_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (30) @(negedge clk);
        out_data_a = 16'hFFFF;
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        wait_valid(0, 200, cyc);
        check_value("t5_valid_seen", valid_a, 1'b1);
        check_value("t5_in_data", in_data_a, 16'h5678);
        check_value("t5_latched_out", latched_a, 16'h3C5A);
`ifdef SERIAL_IO_CHANGE_EN
        check_value("t5_changed", changed_a, 16'h444C);
`else
        check_value("t5_changed", changed_a, 16'h0000);
`endif
        $display("frame t5: out=3c5a in=%h (start during shift)", in_data_a);
        busy_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
        end
        check_value("t5_no_extra_frame", busy_cnt, 0);
        check_value("t5_one_latch_pulse", latch_pulses_a, 1);

        // Reset mid-frame at bit 5
        out_data_a     = 16'h2222;
        in_word_a      = 16'h1111;
        sclk_rises_a   = 0;
        latch_pulses_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sclk_rises_a >= 5) break;
            @(negedge clk);
        end
        check_value("t5_bit5_reached", sclk_rises_a, 5);
        #2 rst = 1'b1;
        #1;
        check_value("t5_rst_outputs", {busy_a, sclk_a, ser_out_a, out_latch_a, in_latch_a, valid_a}, 6'b0);
        check_value("t5_rst_in_data", in_data_a, 16'h0);
        check_value("t5_rst_changed", changed_a, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_value("t5_rst_no_latch", latch_pulses_a, 0);
        check_value("t5_rst_latched_kept", latched_a, 16'h3C5A);
        $display("frame t5r: reset at bit %0d", sclk_rises_a);

        // Change mask across two frames after reset
`ifdef SERIAL_IO_CHANGE_EN
        exp_chg = 16'h00FF;
`else
        exp_chg = 16'h0000;
`endif
        run_frame_a("t6a", 16'h1234, 16'h00FF, exp_chg);
`ifdef SERIAL_IO_CHANGE_EN
        exp_chg = 16'h0FF0;
`else
        exp_chg = 16'h0000;
`endif
        run_frame_a("t6b", 16'hC001, 16'h0F0F, exp_chg);

        // Unequal widths: 8 out (padded to 24), 24 in
        out_data_b   = 8'hF0;
        in_word_b    = 24'hABCDEF;
        sclk_rises_b = 0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        wait_valid(1, 300, cyc);
        check_value("t3_valid_cycle", cyc, 105);
        check_value("t3_in_data", in_data_b, 24'hABCDEF);
        check_value("t3_padded_out", latched_b, 24'h0000F0);
        check_value("t3_sclk_rises", sclk_rises_b, 24);
`ifdef SERIAL_IO_CHANGE_EN
        check_value("t3_changed", changed_b, 24'hABCDEF);
`else
        check_value("t3_changed", changed_b, 24'h0);
`endif
        $display("frame t3: out=f0 in=%h cycles=%0d", in_data_b, cyc);

        // Continuous mode: period and immediate reload
        wait_valid(2, 200, cyc);
        check_value("t4_valid_seen", valid_c, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_value("t4_inlatch_after_done", in_latch_c, 1'b1);
            check_value("t4_busy_after_done", busy_c, 1'b1);
            wait_valid(2, 200, cyc);
            check_value("t4_period", cyc, 73);
            check_value("t4_in_data", in_data_c, 16'hBEEF);
            check_value("t4_latched_out", latched_c, 16'h0F0F);
            check_value("t4_changed", changed_c, 16'h0);
            $display("frame t4.%0d: in=%h period=%0d", k, in_data_c, cyc);
        end

        check_value("strobe_overlap", overlap_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
